countdown_preset_entry: RTL and testbench

User-input front end for the countdown timer: debounces three raw pushbuttons and runs an edit state machine that lets the operator set a two-digit BCD start value (tens/units seconds). It then issues a one-cycle load strobe with that value to the down-counter. It drives the counter's load path, the inverse direction of the counter-to-display/beep path, and also exports which digit is being edited so the 7-segment driver can blink it.

---
 rtl/countdown_pkg.sv | 21 ++
 rtl/countdown_preset_entry_if.sv | 22 ++
 rtl/countdown_preset_entry_btn_debounce.sv | 51 +++++
 rtl/countdown_preset_entry.sv | 99 +++++++++
 tb/tb_countdown_preset_entry.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown preset entry front end.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EDIT_H,
        EDIT_L,
        LOAD
    } preset_state_t;

    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [1:0] EDIT_NONE  = 2'b00;
    localparam logic [1:0] EDIT_TENS  = 2'b01;
    localparam logic [1:0] EDIT_UNITS = 2'b10;

    // Single BCD digit step with 9 -> 0 wrap; never carries.
    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/countdown_preset_entry_if.sv
// Button inputs and preset/load outputs between the operator panel and the counter.
interface countdown_preset_entry_if;

    logic       btn_mode;
    logic       btn_inc;
    logic       btn_start;
    logic [3:0] PresetH;
    logic [3:0] PresetL;
    logic       load;
    logic [1:0] edit_sel;

    modport master (
        output btn_mode, btn_inc, btn_start,
        input  PresetH, PresetL, load, edit_sel
    );

    modport slave (
        input  btn_mode, btn_inc, btn_start,
        output PresetH, PresetL, load, edit_sel
    );

endinterface

// File: rtl/countdown_preset_entry_btn_debounce.sv
// Raw pushbutton -> 2-flop synchroniser -> debounce counter -> one-cycle press event.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 20
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic press
);

    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        level_q, level_d;
    logic        level_prev_q, level_prev_d;
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d      = raw;
        sync2_d      = sync1_q;
        level_prev_d = level_q;
        level_d      = level_q;
        cnt_d        = '0;
        if (sync2_q != level_q) begin
            if (cnt_q + 16'd1 == 16'(DEBOUNCE_CYCLES)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    // Rising edge of the accepted level only; release and hold produce nothing.
    assign press = level_q & ~level_prev_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: rtl/countdown_preset_entry.sv
// Preset edit FSM: sets a two-digit BCD start value and strobes it into the down-counter.
module countdown_preset_entry
    import countdown_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 20,
    parameter logic [3:0]  DEFAULT_H       = 4'd6,
    parameter logic [3:0]  DEFAULT_L       = 4'd0
) (
    input  logic                     clock,
    input  logic                     reset,
    countdown_preset_entry_if.slave  bus
);

    logic p_mode, p_inc, p_start;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clock(clock), .reset(reset), .raw(bus.btn_mode), .press(p_mode)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clock(clock), .reset(reset), .raw(bus.btn_inc), .press(p_inc)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clock(clock), .reset(reset), .raw(bus.btn_start), .press(p_start)
    );

    preset_state_t state_q, state_d;
    logic [3:0]    h_q, h_d;
    logic [3:0]    l_q, l_d;
    logic          load_q, load_d;
    logic [1:0]    sel_q, sel_d;
    logic          nonzero;

    assign nonzero = (h_q != 4'd0) || (l_q != 4'd0);

    // start > mode > inc; a rejected zero start still swallows the lower-priority events.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        l_d     = l_q;
        unique case (state_q)
            IDLE: begin
                if (p_start) begin
                    if (nonzero) state_d = LOAD;
                end else if (p_mode) begin
                    state_d = EDIT_H;
                end
            end
            EDIT_H: begin
                if (p_start) begin
                    if (nonzero) state_d = LOAD;
                end else if (p_mode) begin
                    state_d = EDIT_L;
                end else if (p_inc) begin
                    h_d = bcd_inc(h_q);
                end
            end
            EDIT_L: begin
                if (p_start) begin
                    if (nonzero) state_d = LOAD;
                end else if (p_mode) begin
                    state_d = EDIT_H;
                end else if (p_inc) begin
                    l_d = bcd_inc(l_q);
                end
            end
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        load_d = (state_d == LOAD);
        unique case (state_d)
            EDIT_H:  sel_d = EDIT_TENS;
            EDIT_L:  sel_d = EDIT_UNITS;
            default: sel_d = EDIT_NONE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            h_q     <= DEFAULT_H;
            l_q     <= DEFAULT_L;
            load_q  <= 1'b0;
            sel_q   <= EDIT_NONE;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            l_q     <= l_d;
            load_q  <= load_d;
            sel_q   <= sel_d;
        end
    end

    assign bus.PresetH  = h_q;
    assign bus.PresetL  = l_q;
    assign bus.load     = load_q;
    assign bus.edit_sel = sel_q;

endmodule

// File: tb/tb_countdown_preset_entry.sv
// Directed scoreboard bench for countdown_preset_entry with DEBOUNCE_CYCLES=4, defaults 6,0.
module tb_countdown_preset_entry;

    localparam int unsigned D = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    countdown_preset_entry_if bus();

    countdown_preset_entry #(
        .DEBOUNCE_CYCLES(D),
        .DEFAULT_H(4'd6),
        .DEFAULT_L(4'd0)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus(bus.slave)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   load_cnt = 0;
    logic [3:0] load_h = '0;
    logic [3:0] load_l = '0;
    logic [3:0] h_exp, l_exp;

    // Counts load cycles and captures the preset seen during each one.
    always @(negedge clk) begin
        if (bus.load === 1'b1) begin
            load_cnt++;
            load_h = bus.PresetH;
            load_l = bus.PresetL;
        end
    end

    function automatic logic [31:0] st(input logic [3:0] h, input logic [3:0] l,
                                        input logic [1:0] sel, input logic ld);
        return {21'b0, h, l, sel, ld};
    endfunction

    function automatic logic [31:0] obs();
        return {21'b0, bus.PresetH, bus.PresetL, bus.edit_sel, bus.load};
    endfunction

    task automatic expect_v(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic compare(input logic [31:0] o);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $error("FAIL scoreboard_empty: observed %0h with no expected value", o);
        end else begin
            e = sb.pop_front();
            assert (o === e.val) else begin
                n_bad++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic m, input logic i, input logic s);
        bus.btn_mode  = m;
        bus.btn_inc   = i;
        bus.btn_start = s;
        tick(2 * D);
        bus.btn_mode  = 1'b0;
        bus.btn_inc   = 1'b0;
        bus.btn_start = 1'b0;
        tick(2 * D);
    endtask

    initial begin
        int lc;
        bus.btn_mode  = 1'b0;
        bus.btn_inc   = 1'b0;
        bus.btn_start = 1'b0;
        rst = 1'b1;
        tick(3);
        expect_v("reset_in", st(4'd6, 4'd0, 2'b00, 1'b0));
        compare(obs());
        rst = 1'b0;
        tick(2);
        expect_v("reset_out", st(4'd6, 4'd0, 2'b00, 1'b0));
        compare(obs());

        // 3-cycle glitch on mode: must be filtered
        bus.btn_mode = 1'b1;
        tick(3);
        bus.btn_mode = 1'b0;
        tick(12);
        expect_v("glitch", st(4'd6, 4'd0, 2'b00, 1'b0));
        compare(obs());

        // Held mode: EDIT_H appears exactly 6 edges after the first sampling edge
        bus.btn_mode = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            @(posedge clk);
            #1;
            expect_v($sformatf("latency_e%0d", k),
                     st(4'd6, 4'd0, (k < 6) ? 2'b00 : 2'b01, 1'b0));
            compare(obs());
        end
        tick(3);
        bus.btn_mode = 1'b0;
        tick(12);
        expect_v("hold_once", st(4'd6, 4'd0, 2'b01, 1'b0));
        compare(obs());

        // Ten incs on tens digit with wrap
        h_exp = 4'd6;
        l_exp = 4'd0;
        for (int k = 0; k < 10; k++) begin
            h_exp = (h_exp == 4'd9) ? 4'd0 : h_exp + 4'd1;
            expect_v($sformatf("inc_h%0d", k), st(h_exp, l_exp, 2'b01, 1'b0));
            press(1'b0, 1'b1, 1'b0);
            compare(obs());
        end

        // Units digit up to 9, then wrap without carry
        press(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            l_exp = l_exp + 4'd1;
            press(1'b0, 1'b1, 1'b0);
        end
        expect_v("units_9", st(h_exp, 4'd9, 2'b10, 1'b0));
        compare(obs());
        l_exp = 4'd0;
        expect_v("units_wrap", st(h_exp, l_exp, 2'b10, 1'b0));
        press(1'b0, 1'b1, 1'b0);
        compare(obs());

        // Tens to 0 -> preset 0,0; start must be rejected
        press(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            h_exp = (h_exp == 4'd9) ? 4'd0 : h_exp + 4'd1;
            press(1'b0, 1'b1, 1'b0);
        end
        lc = load_cnt;
        expect_v("zero_start_state", st(4'd0, 4'd0, 2'b01, 1'b0));
        expect_v("zero_start_loads", 32'(lc));
        press(1'b0, 1'b0, 1'b1);
        compare(obs());
        compare(32'(load_cnt));

        // Preset 0,5 then start: single load cycle carrying 0,5
        press(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) press(1'b0, 1'b1, 1'b0);
        lc = load_cnt;
        expect_v("load_after", st(4'd0, 4'd5, 2'b00, 1'b0));
        expect_v("load_count", 32'(lc + 1));
        expect_v("load_value", st(4'd0, 4'd5, 2'b00, 1'b0));
        press(1'b0, 1'b0, 1'b1);
        compare(obs());
        compare(32'(load_cnt));
        compare(st(load_h, load_l, 2'b00, 1'b0));

        // start+inc together in EDIT_H: load wins, no increment
        press(1'b1, 1'b0, 1'b0);
        lc = load_cnt;
        expect_v("start_inc_state", st(4'd0, 4'd5, 2'b00, 1'b0));
        expect_v("start_inc_loads", 32'(lc + 1));
        press(1'b0, 1'b1, 1'b1);
        compare(obs());
        compare(32'(load_cnt));

        // mode+inc together in EDIT_H: to EDIT_L, no increment
        press(1'b1, 1'b0, 1'b0);
        expect_v("mode_inc", st(4'd0, 4'd5, 2'b10, 1'b0));
        press(1'b1, 1'b1, 1'b0);
        compare(obs());

        // Reset mid-EDIT_L with a start press in flight: defaults, no load
        lc = load_cnt;
        bus.btn_start = 1'b1;
        tick(4);
        rst = 1'b1;
        bus.btn_start = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(20);
        expect_v("reset_mid_edit", st(4'd6, 4'd0, 2'b00, 1'b0));
        expect_v("reset_no_load", 32'(lc));
        compare(obs());
        compare(32'(load_cnt));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
